// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a producer/consumer and sync_fifo_param.
interface sync_fifo_param_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_WIDTH-1:0]  count;
    logic                  overflow;
    logic                  underflow;

    // Side that pushes/pops and watches status
    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    // The FIFO itself
    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: arbitrary depth, wrap-around pointers, registered status flags,
// overflow/underflow pulses, and optional first-word-fall-through read data.
module sync_fifo_param #(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH = 1,
    parameter int unsigned FWFT          = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_fifo_param_if.slave   bus
);
    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc_c;
    logic                  rd_acc_c;

    // Advance a pointer, wrapping at the last entry (depth need not be a power of two)
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    // Next-state: accept decisions use the registered flags, flags decode the next count
    always_comb begin
        wr_acc_c    = bus.wr_en && !full_q;
        rd_acc_c    = bus.rd_en && !empty_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        overflow_d  = bus.wr_en && full_q;
        underflow_d = bus.rd_en && empty_q;

        if (wr_acc_c) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_acc_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            if (FWFT == 0) begin
                rd_data_d = mem[rd_ptr_q];
            end
        end

        unique case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        full_d   = (count_d == CNT_WIDTH'(FIFO_DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CNT_WIDTH'(AFULL_THRESH));
        aempty_d = (count_d <= CNT_WIDTH'(AEMPTY_THRESH));
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= (AFULL_THRESH == 0);
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    // In FWFT mode the head entry is presented straight from storage
    assign bus.rd_data      = (FWFT != 0) ? (empty_q ? '0 : mem[rd_ptr_q]) : rd_data_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
